// File: rtl/pdp_cal2d_pipe_chain.sv
// pdp_cal2d_pipe_chain
// Valid/ready pipeline chain of DEPTH bubble-collapsing register stages.
// An optional one-entry input skid (MODE=1) makes in_rdy a register output.
// Also provides a synchronous flush and a live occupancy count.
module pdp_cal2d_pipe_chain #(
    parameter int WIDTH = 115,
    parameter int DEPTH = 1,
    parameter int MODE  = 0,
    parameter int CNT_W = 4
) (
    input  logic             nvdla_op_gated_clk,
    input  logic             nvdla_core_rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_pd,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_pd,
    input  logic             flush,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic             sv_q;
    logic             sv_d;
    logic [WIDTH-1:0] sd_q;
    logic [WIDTH-1:0] sd_d;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;

    logic [DEPTH-1:0] rbc;
    logic             flushAct;
    logic             inRdyRaw;
    logic             srcVld0;
    logic [WIDTH-1:0] srcPd0;
    logic             inAccept;
    logic             outPop;

    // A stage may load when out_rdy is high or any stage at or after it is empty
    always_comb begin
        rbc = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rbc[k] = out_rdy | (|((~v_q) >> k));
        end
    end

    // Upstream side: direct feed (MODE=0) or skid-first feed (MODE=1); flush is ignored under reset
    always_comb begin
        flushAct = flush & ~nvdla_core_rst;
        if (MODE == 1) begin
            inRdyRaw = ~sv_q;
            srcVld0  = sv_q | in_vld;
            srcPd0   = sv_q ? sd_q : in_pd;
        end else begin
            inRdyRaw = rbc[0];
            srcVld0  = in_vld;
            srcPd0   = in_pd;
        end
        in_rdy    = inRdyRaw & ~flushAct;
        out_vld   = v_q[DEPTH-1] & ~flushAct;
        out_pd    = d_q[DEPTH-1];
        occupancy = occ_q;
        inAccept  = in_vld & in_rdy;
        outPop    = out_vld & out_rdy;
    end

    // Next-state for stages, skid and occupancy; flush overrides every transfer
    always_comb begin
        v_d   = v_q;
        d_d   = d_q;
        sv_d  = sv_q;
        sd_d  = sd_q;
        occ_d = occ_q;
        if (flushAct) begin
            v_d   = '0;
            sv_d  = 1'b0;
            occ_d = '0;
        end else begin
            if (rbc[0]) begin
                v_d[0] = srcVld0;
                if (srcVld0) begin
                    d_d[0] = srcPd0;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (rbc[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        d_d[k] = d_q[k-1];
                    end
                end
            end
            if (MODE == 1) begin
                if (sv_q && rbc[0]) begin
                    sv_d = 1'b0;
                end else if (inAccept && !rbc[0]) begin
                    sv_d = 1'b1;
                    sd_d = in_pd;
                end
            end else begin
                sv_d = 1'b0;
            end
            occ_d = occ_q + CNT_W'(inAccept) - CNT_W'(outPop);
        end
    end

    // State registers with asynchronous clear of valids, data and count
    always_ff @(posedge nvdla_op_gated_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            v_q   <= '0;
            sv_q  <= 1'b0;
            sd_q  <= '0;
            occ_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            sv_q  <= sv_d;
            sd_q  <= sd_d;
            occ_q <= occ_d;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

endmodule
